// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int unsigned MULDIV_ITERS   = 32;
  localparam int unsigned MULDIV_LATENCY = 34;

  // Two's-complement magnitude of a 32-bit operand when its sign flag is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    if (neg) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: operand/result handshake between control and the multiply/divide unit.
interface muldiv_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, SrcA, SrcB,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  Start, Op, SrcA, SrcB,
    output Busy, Done, DivZero, HI, LO
  );
endinterface

// File: rtl/muldiv_fix.sv
// muldiv_fix: combinational sign correction applied in the FIX state.
// Multiply: whole 64-bit product negated when operand signs differ.
// Divide: quotient (low word) follows sA^sB, remainder (high word) follows sA.
module muldiv_fix (
  input  logic        is_div_i,
  input  logic        sa_i,
  input  logic        sb_i,
  input  logic [63:0] val_i,
  output logic [63:0] res_o
);

  // Conditional negation of product, or of quotient and remainder independently.
  always_comb begin
    res_o = val_i;
    if (is_div_i) begin
      res_o[31:0]  = (sa_i ^ sb_i) ? (32'd0 - val_i[31:0]) : val_i[31:0];
      res_o[63:32] = sa_i ? (32'd0 - val_i[63:32]) : val_i[63:32];
    end else begin
      res_o = (sa_i ^ sb_i) ? (64'd0 - val_i) : val_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO result registers.
// Build option MULDIV_DIV_EN: when defined the restoring divider is compiled;
// when undefined DIV/DIVU still take the full latency, leave HI/LO untouched
// and report DivZero with Done to flag the unsupported operation.
import muldiv_pkg::*;

module muldiv_unit (
  input  logic    CLK,
  input  logic    RESET_N,
  muldiv_if.slave bus
);

  localparam logic [4:0] CNT_LAST = 5'(MULDIV_ITERS - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] mcand_q, mcand_d;   // multiplicand (mult) or divisor (div) magnitude
  logic [63:0] work_q, work_d;     // {acc_hi, multiplier} or {remainder, dividend/quotient}
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic        accept_s, is_div_s, sgn_s, flag_s, fix_div_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_step_s, fix_s;
`ifdef MULDIV_DIV_EN
  logic        divz_q, divz_d;
  logic [31:0] araw_q, araw_d;
  logic [32:0] div_shift_s, div_trial_s;
  logic [63:0] div_step_s;
`endif

  assign is_div_s = op_q[1];
`ifdef MULDIV_DIV_EN
  assign fix_div_s = is_div_s;
  assign flag_s    = divz_q;
`else
  assign fix_div_s = 1'b0;
  assign flag_s    = is_div_s;
`endif

  muldiv_fix u_fix (
    .is_div_i (fix_div_s),
    .sa_i     (sa_q),
    .sb_i     (sb_q),
    .val_i    (work_q),
    .res_o    (fix_s)
  );

  // Accept decision and FSM next-state; Start outside IDLE/DONE is dropped.
  always_comb begin
    accept_s = bus.Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_CALC;
        else          state_d = ST_IDLE;
      end
      ST_CALC: begin
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
        else                   state_d = ST_CALC;
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        if (accept_s) state_d = ST_CALC;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One shift-add multiply step and (optionally) one restoring divide step.
  always_comb begin
    mul_sum_s = {1'b0, work_q[63:32]} + {1'b0, mcand_q};
    if (work_q[0]) mul_step_s = {mul_sum_s, work_q[31:1]};
    else           mul_step_s = {1'b0, work_q[63:32], work_q[31:1]};
`ifdef MULDIV_DIV_EN
    div_shift_s = {work_q[63:32], work_q[31]};
    div_trial_s = div_shift_s - {1'b0, mcand_q};
    if (!div_trial_s[32]) div_step_s = {div_trial_s[31:0], work_q[30:0], 1'b1};
    else                  div_step_s = {div_shift_s[31:0], work_q[30:0], 1'b0};
`endif
  end

  // Operand latch on accept, iteration in CALC, result write in FIX.
  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mcand_d = mcand_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_s   = ~bus.Op[0];
`ifdef MULDIV_DIV_EN
    divz_d  = divz_q;
    araw_d  = araw_q;
`endif
    if (accept_s) begin
      op_d  = op_e'(bus.Op);
      cnt_d = 5'd0;
      sa_d  = sgn_s & bus.SrcA[31];
      sb_d  = sgn_s & bus.SrcB[31];
      if (bus.Op[1]) begin
        mcand_d = mag32(bus.SrcB, sb_d);
        work_d  = {32'd0, mag32(bus.SrcA, sa_d)};
      end else begin
        mcand_d = mag32(bus.SrcA, sa_d);
        work_d  = {32'd0, mag32(bus.SrcB, sb_d)};
      end
`ifdef MULDIV_DIV_EN
      divz_d = bus.Op[1] && (bus.SrcB == 32'd0);
      araw_d = bus.SrcA;
`endif
    end else if (state_q == ST_CALC) begin
      cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
      if (is_div_s) work_d = div_step_s;
      else          work_d = mul_step_s;
`else
      work_d = mul_step_s;
`endif
    end else if (state_q == ST_FIX) begin
`ifdef MULDIV_DIV_EN
      if (divz_q) begin
        hi_d = araw_q;
        lo_d = 32'hFFFF_FFFF;
      end else begin
        hi_d = fix_s[63:32];
        lo_d = fix_s[31:0];
      end
`else
      if (is_div_s) begin
        hi_d = hi_q;
        lo_d = lo_q;
      end else begin
        hi_d = fix_s[63:32];
        lo_d = fix_s[31:0];
      end
`endif
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered status outputs derived from the next state.
  always_comb begin
    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
    dz_d   = done_d && flag_s;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= 5'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mcand_q <= 32'd0;
      work_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      divz_q  <= 1'b0;
      araw_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mcand_q <= mcand_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef MULDIV_DIV_EN
      divz_q  <= divz_d;
      araw_q  <= araw_d;
`endif
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = dz_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Divide expectations switch on MULDIV_DIV_EN to match the build under test.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   lat;
  int   done_seen;

  muldiv_if bus ();

  muldiv_unit dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation at the current negedge; returns one negedge later with Start low.
  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // Wait for Done, counting negedges since the start was presented; bounded.
  task automatic wait_done(input int lat0, output int lat_o);
    lat_o = lat0;
    while ((bus.Done !== 1'b1) && (lat_o < 80)) begin
      @(negedge clk);
      lat_o++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz);
    int l;
    drive(op, a, b);
    chk({tag, "_busy"}, {63'd0, bus.Busy}, 64'd1);
    wait_done(1, l);
    chk({tag, "_lat"}, 64'(l), 64'd34);
    chk({tag, "_hi"}, {32'd0, bus.HI}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, bus.LO}, {32'd0, elo});
    chk({tag, "_dz"}, {63'd0, bus.DivZero}, {63'd0, edz});
    chk({tag, "_busy_done"}, {63'd0, bus.Busy}, 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {62'd0, bus.Done, bus.DivZero}, 64'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    done_seen = 0;
    rst_n     = 1'b0;
    bus.Start = 1'b1;
    bus.Op    = 2'b00;
    bus.SrcA  = 32'd1;
    bus.SrcB  = 32'd1;

    // Reset with Start asserted: start must be dropped.
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_done", {62'd0, bus.Done, bus.DivZero}, 64'd0);
    chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    rst_n     = 1'b1;
    bus.Start = 1'b0;
    @(negedge clk);
    chk("rst_no_start", {63'd0, bus.Busy}, 64'd0);

    // Multiply cases.
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // Divide cases.
`ifdef MULDIV_DIV_EN
    do_op("div_neg_a", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("div_neg_b", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    do_op("divu_plain", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    do_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
`else
    do_op("div_neg_a", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    do_op("div_neg_b", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    do_op("divu_plain", 2'b11, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    do_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
`endif

    // Start during CALC is ignored; operands changing afterwards have no effect.
    drive(2'b01, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = 2'b00;
    bus.SrcA  = 32'd7;
    bus.SrcB  = 32'd9;
    @(negedge clk);
    bus.Start = 1'b0;
    chk("ign_busy", {63'd0, bus.Busy}, 64'd1);
    wait_done(11, lat);
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_res", {bus.HI, bus.LO}, 64'd15);

    // Start held in DONE begins the next operation with no bubble.
    bus.Start = 1'b1;
    bus.Op    = 2'b01;
    bus.SrcA  = 32'd6;
    bus.SrcB  = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    chk("b2b_busy", {62'd0, bus.Busy, bus.Done}, 64'd2);
    chk("b2b_hold", {bus.HI, bus.LO}, 64'd15);
    wait_done(1, lat);
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_res", {bus.HI, bus.LO}, 64'd42);
    @(negedge clk);

    // Reset in the middle of a MULT; Start during reset is dropped.
    drive(2'b00, 32'h0000_1000, 32'h0000_1000);
    repeat (19) @(negedge clk);
    chk("mid_hold", {bus.HI, bus.LO}, 64'd42);
    rst_n     = 1'b0;
    bus.Start = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {62'd0, bus.Busy, bus.Done}, 64'd0);
    chk("mid_rst_hilo", {bus.HI, bus.LO}, 64'd0);
    rst_n     = 1'b1;
    bus.Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_seen++;
    end
    chk("mid_rst_no_done", 64'(done_seen), 64'd0);
    chk("mid_rst_idle", {63'd0, bus.Busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
